// File: rtl/frame_buffer_pkg.sv
// Shared constants and types for the double-buffered panel frame store.
package frame_buffer_pkg;

  localparam int SCREEN_WIDTH_DEF = 32;
  localparam int SCREEN_DEPTH_DEF = 16;
  localparam int COLOR_BITS_DEF   = 4;

  function automatic int addr_w(input int depth, input int width);
    return $clog2(depth * width);
  endfunction

  localparam int ADDR_W = addr_w(SCREEN_DEPTH_DEF, SCREEN_WIDTH_DEF);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } swap_state_e;

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module fb_ram #(
  parameter int WIDTH  = 12,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/frame_buffer.sv
// Double-buffered pixel store: host writes the back bank, the scan side reads
// bit planes of the front bank; banks swap only on a frame boundary.
module frame_buffer
  import frame_buffer_pkg::*;
#(
  parameter int SCREEN_WIDTH = SCREEN_WIDTH_DEF,
  parameter int SCREEN_DEPTH = SCREEN_DEPTH_DEF,
  parameter int COLOR_BITS   = COLOR_BITS_DEF
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [5:0]              wr_x,
  input  logic [6:0]              wr_y,
  input  logic [3*COLOR_BITS-1:0] wr_rgb,
  input  logic                    swap_req,
  output logic                    swap_done,
  input  logic                    frame_start,
  input  logic                    rd_en,
  input  logic [5:0]              rd_row,
  input  logic [5:0]              rd_col,
  input  logic [3:0]              rd_plane,
  output logic                    rd_valid,
  output logic                    R1_data,
  output logic                    G1_data,
  output logic                    B1_data,
  output logic                    R2_data,
  output logic                    G2_data,
  output logic                    B2_data
);

  localparam int DATA_W  = 3 * COLOR_BITS;
  localparam int WORDS   = SCREEN_DEPTH * SCREEN_WIDTH;
  localparam int AW      = addr_w(SCREEN_DEPTH, SCREEN_WIDTH);
  localparam int PLANE_W = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;

  swap_state_e state_q, state_d;
  logic        front_sel_q, front_sel_d;
  logic        swap_done_q, swap_done_d;

  logic              rd_valid_q, rd_valid_d;
  logic              rd_bank_q, rd_bank_d;
  logic              rd_zero_q, rd_zero_d;
  logic [PLANE_W-1:0] rd_plane_q, rd_plane_d;

  logic              wr_fire;
  logic              wr_in_range;
  logic              wr_bottom;
  int                wr_row;
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     rd_addr;
  logic              ram_we    [4];
  logic [DATA_W-1:0] ram_rdata [4];
  logic [DATA_W-1:0] top_px;
  logic [DATA_W-1:0] bot_px;

  function automatic logic [2:0] plane_bits(input logic [DATA_W-1:0] px,
                                            input logic [PLANE_W-1:0] p);
    logic [COLOR_BITS-1:0] r, g, b;
    r = px[2*COLOR_BITS +: COLOR_BITS];
    g = px[COLOR_BITS +: COLOR_BITS];
    b = px[0 +: COLOR_BITS];
    return {r[p], g[p], b[p]};
  endfunction

  always_comb begin
    state_d     = state_q;
    front_sel_d = front_sel_q;
    swap_done_d = 1'b0;
    wr_ready    = 1'b0;
    case (state_q)
      IDLE: begin
        wr_ready = 1'b1;
        // A frame_start in this same cycle does not complete the swap.
        if (swap_req) state_d = PENDING;
      end
      PENDING: begin
        if (frame_start) begin
          state_d     = IDLE;
          front_sel_d = ~front_sel_q;
          swap_done_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      front_sel_q <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      swap_done_q <= swap_done_d;
    end
  end

  // Write decode: rows at or below the fold land in the bottom RAM.
  always_comb begin
    wr_fire     = wr_valid && wr_ready;
    wr_in_range = (int'(wr_x) < SCREEN_WIDTH) && (int'(wr_y) < 2 * SCREEN_DEPTH);
    wr_bottom   = int'(wr_y) >= SCREEN_DEPTH;
    wr_row      = wr_bottom ? int'(wr_y) - SCREEN_DEPTH : int'(wr_y);
    wr_addr     = AW'(wr_row * SCREEN_WIDTH + int'(wr_x));
    for (int i = 0; i < 4; i++) ram_we[i] = 1'b0;
    if (wr_fire && wr_in_range) ram_we[{~front_sel_q, wr_bottom}] = 1'b1;
  end

  always_comb begin
    rd_addr    = AW'(int'(rd_row) * SCREEN_WIDTH + int'(rd_col));
    rd_valid_d = rd_en;
    rd_bank_d  = rd_bank_q;
    rd_zero_d  = rd_zero_q;
    rd_plane_d = rd_plane_q;
    if (rd_en) begin
      rd_bank_d  = front_sel_q;
      rd_zero_d  = (int'(rd_plane) >= COLOR_BITS) || (int'(rd_row) >= SCREEN_DEPTH) ||
                   (int'(rd_col) >= SCREEN_WIDTH);
      rd_plane_d = rd_plane[PLANE_W-1:0];
    end
  end

  // Zero flag resets high so the data outputs are 0 before the first read.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_zero_q  <= 1'b1;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_bank_q  <= rd_bank_d;
      rd_zero_q  <= rd_zero_d;
    end
  end

  always_ff @(posedge clk_in) begin
    rd_plane_q <= rd_plane_d;
  end

  for (genvar i = 0; i < 4; i++) begin : g_ram
    fb_ram #(
      .WIDTH (DATA_W),
      .DEPTH (WORDS),
      .ADDR_W(AW)
    ) u_ram (
      .clk  (clk_in),
      .we   (ram_we[i]),
      .waddr(wr_addr),
      .wdata(wr_rgb),
      .re   (rd_en),
      .raddr(rd_addr),
      .rdata(ram_rdata[i])
    );
  end

  // RAM index is {bank, bottom}.
  always_comb begin
    top_px = rd_bank_q ? ram_rdata[2] : ram_rdata[0];
    bot_px = rd_bank_q ? ram_rdata[3] : ram_rdata[1];
    {R1_data, G1_data, B1_data} = rd_zero_q ? 3'b000 : plane_bits(top_px, rd_plane_q);
    {R2_data, G2_data, B2_data} = rd_zero_q ? 3'b000 : plane_bits(bot_px, rd_plane_q);
  end

  assign swap_done = swap_done_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_frame_buffer.sv
// Directed bench for frame_buffer with a reference model and read scoreboard.
module tb_frame_buffer;

  logic        clk_in = 1'b0;
  logic        rst = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [5:0]  wr_x = '0;
  logic [6:0]  wr_y = '0;
  logic [11:0] wr_rgb = '0;
  logic        swap_req = 1'b0;
  logic        swap_done;
  logic        frame_start = 1'b0;
  logic        rd_en = 1'b0;
  logic [5:0]  rd_row = '0;
  logic [5:0]  rd_col = '0;
  logic [3:0]  rd_plane = '0;
  logic        rd_valid;
  logic        R1_data, G1_data, B1_data, R2_data, G2_data, B2_data;

  frame_buffer dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_rgb     (wr_rgb),
    .swap_req   (swap_req),
    .swap_done  (swap_done),
    .frame_start(frame_start),
    .rd_en      (rd_en),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_plane   (rd_plane),
    .rd_valid   (rd_valid),
    .R1_data    (R1_data),
    .G1_data    (G1_data),
    .B1_data    (B1_data),
    .R2_data    (R2_data),
    .G2_data    (G2_data),
    .B2_data    (B2_data)
  );

  always #5 clk_in = ~clk_in;

  logic [11:0] mem [2][32][32];
  int          f = 0;
  int          pending = 0;
  int          errors = 0;
  int          checks = 0;
  logic [5:0]  exp_q [$];
  logic [5:0]  mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [5:0] model_read(input int row, input int col, input int plane);
    logic [11:0] t, b;
    if (plane >= 4 || row >= 16 || col >= 32) return 6'b0;
    t = mem[f][row][col];
    b = mem[f][row + 16][col];
    return {t[8 + plane], t[4 + plane], t[plane], b[8 + plane], b[4 + plane], b[plane]};
  endfunction

  // One clock of stimulus; the model advances with the same cycle semantics.
  task automatic step(input logic wv, input int x, input int y, input logic [11:0] rgb,
                      input logic sreq, input logic fs, input logic re,
                      input int row, input int col, input int plane, input string tag);
    logic sd;
    wr_valid = wv; wr_x = 6'(x); wr_y = 7'(y); wr_rgb = rgb;
    swap_req = sreq; frame_start = fs;
    rd_en = re; rd_row = 6'(row); rd_col = 6'(col); rd_plane = 4'(plane);
    if (re) exp_q.push_back(model_read(row, col, plane));
    if (wv && pending == 0 && x < 32 && y < 32) mem[1 - f][y][x] = rgb;
    sd = (pending == 1) && fs;
    if (pending == 1 && fs) begin
      pending = 0;
      f = 1 - f;
    end else if (pending == 0 && sreq) begin
      pending = 1;
    end
    @(posedge clk_in);
    @(negedge clk_in);
    wr_valid = 1'b0; swap_req = 1'b0; frame_start = 1'b0; rd_en = 1'b0;
    chk({tag, "_wr_ready"}, wr_ready, pending == 0);
    chk({tag, "_swap_done"}, swap_done, sd);
    chk({tag, "_rd_valid"}, rd_valid, re);
  endtask

  task automatic wr(input int x, input int y, input logic [11:0] rgb, input string tag);
    step(1'b1, x, y, rgb, 1'b0, 1'b0, 1'b0, 0, 0, 0, tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 0, 0, 12'h0, 1'b0, 1'b0, 1'b0, 0, 0, 0, tag);
  endtask

  task automatic rd(input int row, input int col, input int plane, input string tag);
    step(1'b0, 0, 0, 12'h0, 1'b0, 1'b0, 1'b1, row, col, plane, tag);
  endtask

  task automatic swap(input string tag);
    step(1'b0, 0, 0, 12'h0, 1'b1, 1'b0, 1'b0, 0, 0, 0, {tag, "_req"});
    step(1'b0, 0, 0, 12'h0, 1'b0, 1'b1, 1'b0, 0, 0, 0, {tag, "_fs"});
  endtask

  always @(negedge clk_in) begin
    if (rd_valid === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL rd_unexpected: observed=rd_valid with no read outstanding expected=none");
      end
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("rd_data", {R1_data, G1_data, B1_data, R2_data, G2_data, B2_data}, mon_e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    chk("reset_wr_ready", wr_ready, 1);
    chk("reset_swap_done", swap_done, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_data", {R1_data, G1_data, B1_data, R2_data, G2_data, B2_data}, 0);
    rst = 1'b0;
    idle("post_reset");

    // Give every read location a known value in both banks.
    for (int b = 0; b < 2; b++) begin
      wr(3, 2, 12'h000, "init"); wr(3, 18, 12'h000, "init");
      wr(5, 4, 12'h000, "init"); wr(5, 20, 12'h000, "init");
      swap("init_swap");
    end

    wr(3, 2, 12'hF00, "wr_red");
    swap("swap1");
    for (int p = 0; p < 4; p++) rd(2, 3, p, "rd_red");
    idle("hold");
    chk("hold_data", {R1_data, G1_data, B1_data, R2_data, G2_data, B2_data}, 6'b100000);

    wr(5, 20, 12'h0A5, "wr_bottom");
    swap("swap2");
    for (int p = 0; p < 4; p++) rd(4, 5, p, "rd_bottom");

    step(1'b0, 0, 0, 12'h0, 1'b1, 1'b0, 1'b0, 0, 0, 0, "pend_req");
    for (int i = 0; i < 3; i++) wr(3, 2, 12'h0FF, "pend_wr");
    step(1'b0, 0, 0, 12'h0, 1'b0, 1'b1, 1'b0, 0, 0, 0, "pend_fs");
    for (int p = 0; p < 4; p++) rd(2, 3, p, "rd_after_pend");

    step(1'b0, 0, 0, 12'h0, 1'b1, 1'b1, 1'b0, 0, 0, 0, "coinc");
    idle("coinc_wait");
    step(1'b0, 0, 0, 12'h0, 1'b0, 1'b1, 1'b1, 4, 5, 0, "coinc_fs_rd_old");
    rd(4, 5, 0, "rd_new_front");

    wr(40, 2, 12'hFFF, "bad_x40");
    wr(35, 1, 12'hFFF, "bad_x35");
    wr(3, 32, 12'hFFF, "bad_y32");
    wr(3, 34, 12'hFFF, "bad_y34");
    swap("swap3");
    for (int p = 0; p < 4; p++) rd(2, 3, p, "rd_after_bad");
    rd(2, 3, 4, "rd_plane4");
    rd(16, 3, 0, "rd_row16");
    rd(2, 32, 0, "rd_col32");
    idle("flush");

    step(1'b0, 0, 0, 12'h0, 1'b1, 1'b0, 1'b0, 0, 0, 0, "rst_pend_req");
    rst = 1'b1;
    #1;
    chk("rst_mid_wr_ready", wr_ready, 1);
    chk("rst_mid_data", {R1_data, G1_data, B1_data, R2_data, G2_data, B2_data}, 0);
    pending = 0;
    f = 0;
    @(negedge clk_in);
    rst = 1'b0;
    step(1'b0, 0, 0, 12'h0, 1'b0, 1'b1, 1'b0, 0, 0, 0, "rst_fs_no_swap");
    rd(2, 3, 0, "rd_front0");
    rd(4, 5, 0, "rd_front0b");
    idle("final");
    idle("final2");
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
